// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for a 1R/1W register file: round-robin arbitration between
// ALU (port 0) and load unit (port 1), zero-fill sweep after reset or clear, x0 writes dropped.
module regfile_wr_sched #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ADR_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_req,
   input  logic                 req0_valid,
   input  logic [ADR_WIDTH-1:0] req0_addr,
   input  logic [WIDTH-1:0]     req0_data,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [ADR_WIDTH-1:0] req1_addr,
   input  logic [WIDTH-1:0]     req1_data,
   output logic                 req1_ready,
   output logic                 mem_we,
   output logic [ADR_WIDTH-1:0] mem_wr_addr,
   output logic [WIDTH-1:0]     mem_wr_din,
   output logic                 init_busy
);

   typedef enum logic {INIT, RUN} state_t;

   state_t                 state_q, state_d;
   logic [ADR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   last_grant_q, last_grant_d;
   logic                   mem_we_q, mem_we_d;
   logic [ADR_WIDTH-1:0]   addr_q, addr_d;
   logic [WIDTH-1:0]       din_q, din_d;
   logic                   gnt0, gnt1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= INIT;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         mem_we_q     <= 1'b0;
         addr_q       <= '0;
         din_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         mem_we_q     <= mem_we_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      mem_we_d     = 1'b0;
      addr_d       = addr_q;
      din_d        = din_q;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      case (state_q)
         INIT: begin
            // clr_req is deliberately ignored here; the running sweep is not restarted
            mem_we_d = 1'b1;
            addr_d   = cnt_q;
            din_d    = '0;
            cnt_d    = cnt_q + ADR_WIDTH'(1);
            if (cnt_q == '1) state_d = RUN;
         end
         RUN: begin
            if (clr_req) begin
               state_d = INIT;
               cnt_d   = '0;
            end else begin
               // on a tie the port that did not win last time is served
               gnt0 = req0_valid && (!req1_valid || last_grant_q);
               gnt1 = req1_valid && (!req0_valid || !last_grant_q);
               if (gnt0) begin
                  last_grant_d = 1'b0;
                  if (req0_addr != '0) begin
                     mem_we_d = 1'b1;
                     addr_d   = req0_addr;
                     din_d    = req0_data;
                  end
               end else if (gnt1) begin
                  last_grant_d = 1'b1;
                  if (req1_addr != '0) begin
                     mem_we_d = 1'b1;
                     addr_d   = req1_addr;
                     din_d    = req1_data;
                  end
               end
            end
         end
         default: state_d = INIT;
      endcase
   end

   assign req0_ready  = gnt0;
   assign req1_ready  = gnt1;
   assign mem_we      = mem_we_q;
   assign mem_wr_addr = addr_q;
   assign mem_wr_din  = din_q;
   assign init_busy   = (state_q == INIT);

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed self-checking bench for regfile_wr_sched (default 32x32 configuration).
module tb_regfile_wr_sched;

   localparam int unsigned W  = 32;
   localparam int unsigned AW = 5;

   logic          clk;
   logic          rst;
   logic          clr_req;
   logic          req0_valid, req1_valid;
   logic [AW-1:0] req0_addr, req1_addr;
   logic [W-1:0]  req0_data, req1_data;
   logic          req0_ready, req1_ready;
   logic          mem_we;
   logic [AW-1:0] mem_wr_addr;
   logic [W-1:0]  mem_wr_din;
   logic          init_busy;

   int checks;
   int failures;

   regfile_wr_sched #(.WIDTH(W), .ADR_WIDTH(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .clr_req     (clr_req),
      .req0_valid  (req0_valid),
      .req0_addr   (req0_addr),
      .req0_data   (req0_data),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_addr   (req1_addr),
      .req1_data   (req1_data),
      .req1_ready  (req1_ready),
      .mem_we      (mem_we),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_din  (mem_wr_din),
      .init_busy   (init_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Positions the bench 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; clr_req = 1'b0;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      #3;
      checks++;
      if (mem_we !== 1'b0 || mem_wr_addr !== 5'd0 || mem_wr_din !== 32'd0 || init_busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_vals: we=%b addr=%0d din=%h busy=%b, want we=0 addr=0 din=0 busy=1",
                  mem_we, mem_wr_addr, mem_wr_din, init_busy);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         step();
         checks++;
         if (mem_we !== 1'b1 || mem_wr_addr !== AW'(i) || mem_wr_din !== 32'd0 ||
             init_busy !== (i < 31)) begin
            failures++;
            $display("FAIL sweep[%0d]: we=%b addr=%0d din=%h busy=%b, want we=1 addr=%0d din=0 busy=%0b",
                     i, mem_we, mem_wr_addr, mem_wr_din, init_busy, i, (i < 31));
         end
      end
      step();
      checks++;
      if (mem_we !== 1'b0 || mem_wr_addr !== 5'd31) begin
         failures++;
         $display("FAIL post_sweep_idle: we=%b addr=%0d, want we=0 addr=31", mem_we, mem_wr_addr);
      end
   endtask

   task automatic test_contention();
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
      req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
      for (int k = 0; k < 4; k++) begin
         logic want1;
         want1 = (k % 2) == 1;
         #1;
         checks++;
         if (req0_ready !== !want1 || req1_ready !== want1) begin
            failures++;
            $display("FAIL rr_grant[%0d]: rdy0=%b rdy1=%b, want rdy0=%b rdy1=%b",
                     k, req0_ready, req1_ready, !want1, want1);
         end
         step();
         checks++;
         if (mem_we !== 1'b1 || mem_wr_addr !== (want1 ? 5'd4 : 5'd3) ||
             mem_wr_din !== (want1 ? 32'h22 : 32'h11)) begin
            failures++;
            $display("FAIL rr_write[%0d]: we=%b addr=%0d din=%h, want we=1 addr=%0d din=%h",
                     k, mem_we, mem_wr_addr, mem_wr_din, want1 ? 4 : 3, want1 ? 32'h22 : 32'h11);
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
   endtask

   task automatic test_single();
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL single_ready: rdy0=%b rdy1=%b, want rdy0=1 rdy1=0", req0_ready, req1_ready);
      end
      step();
      req0_valid = 1'b0;
      checks++;
      if (mem_we !== 1'b1 || mem_wr_addr !== 5'd5 || mem_wr_din !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL single_write: we=%b addr=%0d din=%h, want we=1 addr=5 din=deadbeef",
                  mem_we, mem_wr_addr, mem_wr_din);
      end
      step();
      checks++;
      if (mem_we !== 1'b0 || mem_wr_addr !== 5'd5) begin
         failures++;
         $display("FAIL single_once: we=%b addr=%0d, want we=0 addr=5", mem_we, mem_wr_addr);
      end
   endtask

   task automatic test_x0_discard();
      req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFFFFFF;
      #1;
      checks++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
         failures++;
         $display("FAIL x0_ready: rdy0=%b rdy1=%b, want rdy0=0 rdy1=1", req0_ready, req1_ready);
      end
      step();
      req1_valid = 1'b0;
      checks++;
      if (mem_we !== 1'b0) begin
         failures++;
         $display("FAIL x0_we: we=%b, want 0", mem_we);
      end
   endtask

   task automatic test_clear_mid_traffic();
      req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
      clr_req = 1'b1;
      #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL clr_ready: rdy0=%b rdy1=%b, want both 0", req0_ready, req1_ready);
      end
      step();
      clr_req = 1'b0;
      #1;
      checks++;
      if (init_busy !== 1'b1 || mem_we !== 1'b0 || req0_ready !== 1'b0) begin
         failures++;
         $display("FAIL clr_enter: busy=%b we=%b rdy0=%b, want busy=1 we=0 rdy0=0",
                  init_busy, mem_we, req0_ready);
      end
      for (int i = 0; i < 32; i++) begin
         step();
         checks++;
         if (mem_we !== 1'b1 || mem_wr_addr !== AW'(i) || mem_wr_din !== 32'd0 ||
             init_busy !== (i < 31) || req0_ready !== (i == 31)) begin
            failures++;
            $display("FAIL clr_sweep[%0d]: we=%b addr=%0d din=%h busy=%b rdy0=%b, want we=1 addr=%0d din=0 busy=%0b rdy0=%0b",
                     i, mem_we, mem_wr_addr, mem_wr_din, init_busy, req0_ready, i, (i < 31), (i == 31));
         end
      end
      step();
      req0_valid = 1'b0;
      checks++;
      if (mem_we !== 1'b1 || mem_wr_addr !== 5'd7 || mem_wr_din !== 32'h77) begin
         failures++;
         $display("FAIL clr_resume: we=%b addr=%0d din=%h, want we=1 addr=7 din=77",
                  mem_we, mem_wr_addr, mem_wr_din);
      end
   endtask

   task automatic test_reset_mid_sweep();
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int i = 0; i < 18; i++) step();
      checks++;
      if (mem_wr_addr !== 5'd17 || mem_we !== 1'b1) begin
         failures++;
         $display("FAIL pre_rst_addr: addr=%0d we=%b, want addr=17 we=1", mem_wr_addr, mem_we);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (mem_we !== 1'b0 || mem_wr_addr !== 5'd0 || mem_wr_din !== 32'd0 || init_busy !== 1'b1) begin
         failures++;
         $display("FAIL async_rst: we=%b addr=%0d din=%h busy=%b, want we=0 addr=0 din=0 busy=1",
                  mem_we, mem_wr_addr, mem_wr_din, init_busy);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (mem_we !== 1'b1 || mem_wr_addr !== AW'(i) || init_busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_restart[%0d]: we=%b addr=%0d busy=%b, want we=1 addr=%0d busy=1",
                     i, mem_we, mem_wr_addr, init_busy, i);
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_contention();
      test_single();
      test_x0_discard();
      test_clear_mid_traffic();
      test_reset_mid_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
